// File: rtl/frame_layer_arbiter.sv
// Pixel layer arbiter: fixed-priority HUD/bird/pig/block/background mux
// with per-frame bird collision flags, a collision pulse and a frame counter.
// Ports: clk, resetN (async, active-low), startOfFrame, per-layer DrawReq/RGB,
// boardersDrawReq, BG_RGB -> RGBOut, layerSel, col* flags,
// collisionPulse, frameCount.
module frame_layer_arbiter #(
  parameter logic [7:0] TRANSPARENT = 8'hFF,
  parameter int         FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   hudDrawReq,
  input  logic [7:0]             hudRGB,
  input  logic                   birdDrawReq,
  input  logic [7:0]             birdRGB,
  input  logic                   pigDrawReq,
  input  logic [7:0]             pigRGB,
  input  logic                   blockDrawReq,
  input  logic [7:0]             blockRGB,
  input  logic                   boardersDrawReq,
  input  logic [7:0]             BG_RGB,
  output logic [7:0]             RGBOut,
  output logic [2:0]             layerSel,
  output logic                   colBirdPig,
  output logic                   colBirdBlock,
  output logic                   colBirdBorder,
  output logic                   collisionPulse,
  output logic [FRAME_CNT_W-1:0] frameCount
);

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] acc;
  logic [2:0] acc_nx;
  logic [2:0] ov;
  logic       publish;
  logic [7:0] pix_nx;
  logic [2:0] sel_nx;

  logic hud_on;
  logic bird_on;
  logic pig_on;
  logic block_on;

  assign hud_on   = hudDrawReq   && (hudRGB   != TRANSPARENT);
  assign bird_on  = birdDrawReq  && (birdRGB  != TRANSPARENT);
  assign pig_on   = pigDrawReq   && (pigRGB   != TRANSPARENT);
  assign block_on = blockDrawReq && (blockRGB != TRANSPARENT);

  // bit 0 bird/pig, bit 1 bird/block, bit 2 bird/border; HUD never collides
  assign ov = {bird_on && boardersDrawReq,
               bird_on && block_on,
               bird_on && pig_on};

  always_comb begin
    pix_nx = BG_RGB;
    sel_nx = 3'd0;
    if (hud_on) begin
      pix_nx = hudRGB;
      sel_nx = 3'd4;
    end else if (bird_on) begin
      pix_nx = birdRGB;
      sel_nx = 3'd3;
    end else if (pig_on) begin
      pix_nx = pigRGB;
      sel_nx = 3'd2;
    end else if (block_on) begin
      pix_nx = blockRGB;
      sel_nx = 3'd1;
    end
  end

  // SOF cycle overlaps seed the new frame rather than the published one
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    publish  = 1'b0;
    unique case (state)
      WAIT_SOF: begin
        acc_nx = 3'b000;
        if (startOfFrame) state_nx = ACTIVE;
      end
      ACTIVE: begin
        if (startOfFrame) begin
          publish = 1'b1;
          acc_nx  = ov;
        end else begin
          acc_nx = acc | ov;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= WAIT_SOF;
      acc   <= 3'b000;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      RGBOut   <= 8'h00;
      layerSel <= 3'd0;
    end else begin
      RGBOut   <= pix_nx;
      layerSel <= sel_nx;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      colBirdPig     <= 1'b0;
      colBirdBlock   <= 1'b0;
      colBirdBorder  <= 1'b0;
      collisionPulse <= 1'b0;
      frameCount     <= '0;
    end else begin
      collisionPulse <= 1'b0;
      if (publish) begin
        colBirdPig     <= acc[0];
        colBirdBlock   <= acc[1];
        colBirdBorder  <= acc[2];
        collisionPulse <= |acc;
        frameCount     <= frameCount + FRAME_CNT_W'(1);
      end
    end
  end

endmodule
